// File: rtl/shift_driver_pkg.sv
// Shared types and MODE encodings for the shift register driver.
// States IDLE/SHIFT/PAR/FIN; PAR is only entered with SHIFT_DRIVER_PARALLEL_EN.
package shift_driver_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [1:0] MODE_HOLD   = 2'b00;
    localparam logic [1:0] MODE_RSHIFT = 2'b01;
    localparam logic [1:0] MODE_LSHIFT = 2'b10;
    localparam logic [1:0] MODE_LOAD   = 2'b11;

endpackage

// File: rtl/shift_driver_bitsel.sv
// Serial bit picker: word[idx] for right-shift, word[WIDTH-1-idx] for left.
// Ports: word_i, idx_i, left_i in; bit_o out. Purely combinational.
module shift_driver_bitsel
    import shift_driver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]         word_i,
    input  logic [$clog2(WIDTH)-1:0] idx_i,
    input  logic                     left_i,
    output logic                     bit_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] ridx;

    always_comb begin
        ridx  = LAST - idx_i;
        bit_o = left_i ? word_i[ridx] : word_i[idx_i];
    end

endmodule

// File: rtl/shift_register_driver.sv
// Drives MODE/DATAIN of a universal shift register from a valid/ready request.
// In: clock, reset (async low), VALID, DATAIN, MODE. Out: READY, TXMODE,
// TXDATA, DONE, ERR (all registered). SHIFT_DRIVER_PARALLEL_EN enables MODE 11.
module shift_register_driver
    import shift_driver_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             VALID,
    input  logic [WIDTH-1:0] DATAIN,
    input  logic [1:0]       MODE,
    output logic             READY,
    output logic [1:0]       TXMODE,
    output logic [WIDTH-1:0] TXDATA,
    output logic             DONE,
    output logic             ERR
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;
    logic [WIDTH-1:0] word_q;
    logic [1:0]       mode_q;
    logic             ready_q;
    logic [1:0]       txmode_q;
    logic [WIDTH-1:0] txdata_q;
    logic             done_q;
    logic             err_q;

    logic             accept;
    logic [WIDTH-1:0] sel_word;
    logic [CW-1:0]    sel_idx;
    logic             sel_left;
    logic             sel_bit;
    logic [WIDTH-1:0] ser_word;

    assign accept = ready_q && VALID;
    assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;

    // The first bit is registered on the accept edge, so it is picked
    // straight from the incoming word; later bits come from the latch.
    always_comb begin
        sel_word = accept ? DATAIN : word_q;
        sel_idx  = accept ? '0 : cnt_d;
        sel_left = accept ? (MODE == MODE_LSHIFT)
                          : (mode_q == MODE_LSHIFT);
        ser_word = {{(WIDTH-1){1'b0}}, sel_bit};
    end

    shift_driver_bitsel #(
        .WIDTH(WIDTH)
    ) u_bitsel (
        .word_i(sel_word),
        .idx_i (sel_idx),
        .left_i(sel_left),
        .bit_o (sel_bit)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            word_q   <= '0;
            mode_q   <= MODE_HOLD;
            ready_q  <= 1'b0;
            txmode_q <= MODE_HOLD;
            txdata_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (accept) begin
                word_q  <= DATAIN;
                mode_q  <= MODE;
                cnt_q   <= '0;
                ready_q <= 1'b0;
                unique case (MODE)
                    MODE_RSHIFT, MODE_LSHIFT: begin
                        state_q  <= SHIFT;
                        txmode_q <= MODE;
                        txdata_q <= ser_word;
                    end
`ifdef SHIFT_DRIVER_PARALLEL_EN
                    MODE_LOAD: begin
                        state_q  <= PAR;
                        txmode_q <= MODE_LOAD;
                        txdata_q <= DATAIN;
                    end
`endif
                    default: begin
                        // Null request, or an unsupported load: no activity.
                        state_q  <= FIN;
                        txmode_q <= MODE_HOLD;
                        txdata_q <= '0;
                        ready_q  <= 1'b1;
                        done_q   <= (MODE == MODE_HOLD);
                        err_q    <= (MODE != MODE_HOLD);
                    end
                endcase
            end else begin
                unique case (state_q)
                    SHIFT: begin
                        cnt_q <= cnt_d;
                        if (cnt_q == LAST) begin
                            state_q  <= FIN;
                            txmode_q <= MODE_HOLD;
                            txdata_q <= '0;
                            ready_q  <= 1'b1;
                            done_q   <= 1'b1;
                        end else begin
                            txdata_q <= ser_word;
                        end
                    end
                    PAR: begin
                        state_q  <= FIN;
                        txmode_q <= MODE_HOLD;
                        txdata_q <= '0;
                        ready_q  <= 1'b1;
                        done_q   <= 1'b1;
                    end
                    FIN: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign READY  = ready_q;
    assign TXMODE = txmode_q;
    assign TXDATA = txdata_q;
    assign DONE   = done_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_shift_register_driver.sv
// Bench for shift_register_driver: symbol-queue model plus a shift register
// model fed by the driver. SHIFT_DRIVER_PARALLEL_EN selects MODE 11 behaviour.
module tb_shift_register_driver;

    localparam int W = 4;

    logic         clock  = 1'b0;
    logic         reset  = 1'b0;
    logic         VALID  = 1'b0;
    logic [W-1:0] DATAIN = '0;
    logic [1:0]   MODE   = 2'b00;
    logic         READY;
    logic [1:0]   TXMODE;
    logic [W-1:0] TXDATA;
    logic         DONE;
    logic         ERR;

    shift_register_driver #(.WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .VALID (VALID),
        .DATAIN(DATAIN),
        .MODE  (MODE),
        .READY (READY),
        .TXMODE(TXMODE),
        .TXDATA(TXDATA),
        .DONE  (DONE),
        .ERR   (ERR)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Downstream universal shift register driven by the DUT.
    logic [W-1:0] sreg = '0;
    always @(posedge clock) begin
        case (TXMODE)
            2'b01:   sreg <= {TXDATA[0], sreg[W-1:1]};
            2'b10:   sreg <= {sreg[W-2:0], TXDATA[0]};
            2'b11:   sreg <= TXDATA;
            default: sreg <= sreg;
        endcase
    end

    // Cumulative activity counters.
    logic [W-1:0] seq = '0;
    int nshift = 0, npar = 0, nact = 0, ndone = 0, nerr = 0;
    always @(negedge clock) begin
        if (TXMODE == 2'b01 || TXMODE == 2'b10) begin
            seq = {seq[W-2:0], TXDATA[0]};
            nshift++;
        end
        if (TXMODE == 2'b11) npar++;
        if (TXMODE != 2'b00) nact++;
        if (DONE) ndone++;
        if (ERR) nerr++;
    end

    // Model: each accepted request becomes a list of per-cycle symbols.
    typedef struct packed {
        logic [1:0]   m;
        logic [W-1:0] d;
        logic         r;
        logic         dn;
        logic         er;
    } ent_t;

    function automatic ent_t mk(input logic [1:0] m, input logic [W-1:0] d,
                                input logic r, input logic dn, input logic er);
        ent_t e;
        e.m = m; e.d = d; e.r = r; e.dn = dn; e.er = er;
        return e;
    endfunction

    ent_t q[$];
    ent_t expv = '0;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            q.delete();
            expv = '0;
        end else begin
            if (expv.r && VALID) begin
                q.delete();
                case (MODE)
                    2'b01: begin
                        for (int i = 0; i < W; i++)
                            q.push_back(mk(2'b01, W'(DATAIN[i]), 0, 0, 0));
                        q.push_back(mk(2'b00, '0, 1, 1, 0));
                    end
                    2'b10: begin
                        for (int i = 0; i < W; i++)
                            q.push_back(mk(2'b10, W'(DATAIN[W-1-i]), 0, 0, 0));
                        q.push_back(mk(2'b00, '0, 1, 1, 0));
                    end
                    2'b11: begin
`ifdef SHIFT_DRIVER_PARALLEL_EN
                        q.push_back(mk(2'b11, DATAIN, 0, 0, 0));
                        q.push_back(mk(2'b00, '0, 1, 1, 0));
`else
                        q.push_back(mk(2'b00, '0, 1, 0, 1));
`endif
                    end
                    default: q.push_back(mk(2'b00, '0, 1, 1, 0));
                endcase
            end else if (q.size() > 0) begin
                void'(q.pop_front());
            end
            expv = (q.size() > 0) ? q[0] : mk(2'b00, '0, 1, 0, 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    time t_acc;
    int b_shift, b_par, b_act, b_done, b_err;

    task automatic snap();
        b_shift = nshift; b_par = npar; b_act = nact;
        b_done = ndone; b_err = nerr;
    endtask

    task automatic send(input logic [W-1:0] w, input logic [1:0] m);
        int n;
        n = 0;
        @(negedge clock);
        VALID = 1'b1; DATAIN = w; MODE = m;
        while (!READY && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("accept_ready", 32'(READY), 1);
        @(posedge clock);
        t_acc = $time;
        snap();
        @(negedge clock);
        VALID = 1'b0; DATAIN = '0; MODE = 2'b00;
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(DONE || ERR) && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk("frame_end", 32'(DONE || ERR), 1);
        @(posedge clock);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not end");
        $fatal(1);
    end

    initial begin
        time t1, t2;
        int n;
        fork
            forever begin
                @(negedge clock);
                checks++;
                if ({TXMODE, TXDATA, READY, DONE, ERR} !== expv) begin
                    errors++;
                    $display("FAIL cycle t=%0t: got m=%b d=%h r=%b dn=%b er=%b expected m=%b d=%h r=%b dn=%b er=%b",
                             $time, TXMODE, TXDATA, READY, DONE, ERR,
                             expv.m, expv.d, expv.r, expv.dn, expv.er);
                end
            end
        join_none

        repeat (3) @(negedge clock);
        chk("reset_outputs", 32'({READY, DONE, ERR, TXMODE, TXDATA}), 0);
        reset = 1'b1;
        @(negedge clock);
        chk("ready_after_reset", 32'(READY), 1);

        send(4'b1011, 2'b01);
        wait_end();
        chk("rshift_seq", 32'(seq), 32'b1101);
        chk("rshift_cycles", nshift - b_shift, 4);
        chk("rshift_dataout", 32'(sreg), 32'b1011);
        chk("rshift_done", ndone - b_done, 1);

        send(4'b1011, 2'b10);
        wait_end();
        chk("lshift_seq", 32'(seq), 32'b1011);
        chk("lshift_cycles", nshift - b_shift, 4);
        chk("lshift_dataout", 32'(sreg), 32'b1011);

        send(4'hA, 2'b11);
        wait_end();
`ifdef SHIFT_DRIVER_PARALLEL_EN
        chk("par_cycles", npar - b_par, 1);
        chk("par_dataout", 32'(sreg), 32'hA);
        chk("par_done", ndone - b_done, 1);
        chk("par_err", nerr - b_err, 0);
`else
        chk("rej_err", nerr - b_err, 1);
        chk("rej_active", nact - b_act, 0);
        chk("rej_dataout", 32'(sreg), 32'b1011);
        chk("rej_done", ndone - b_done, 0);
`endif

        @(negedge clock);
        VALID = 1'b1; DATAIN = 4'h3; MODE = 2'b01;
        n = 0;
        while (!READY && n < 20) begin @(negedge clock); n++; end
        chk("b2b_ready1", 32'(READY), 1);
        @(posedge clock);
        t1 = $time;
        snap();
        @(negedge clock);
        DATAIN = 4'hC; MODE = 2'b10;
        n = 0;
        while (!READY && n < 20) begin @(negedge clock); n++; end
        chk("b2b_ready2", 32'(READY), 1);
        @(posedge clock);
        t2 = $time;
        @(negedge clock);
        VALID = 1'b0; DATAIN = '0; MODE = 2'b00;
        wait_end();
        chk("b2b_spacing", 32'((t2 - t1) / 10), 5);
        chk("b2b_done", ndone - b_done, 2);
        chk("b2b_dataout", 32'(sreg), 32'hC);

        send(4'h9, 2'b01);
        @(posedge clock);
        @(posedge clock);
        #3 reset = 1'b0;
        #1 chk("abort_outputs", 32'({READY, DONE, ERR, TXMODE, TXDATA}), 0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_no_done", ndone - b_done, 0);
        send(4'h6, 2'b01);
        wait_end();
        chk("after_abort_dataout", 32'(sreg), 32'h6);

        send(4'h5, 2'b00);
        wait_end();
        chk("null_dataout", 32'(sreg), 32'h6);
        chk("null_active", nact - b_act, 0);
        chk("null_done", ndone - b_done, 1);

        repeat (3) @(negedge clock);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
